// File: rtl/sw_debounce_if.sv
// -----------------------------------------------------------------------------
// sw_debounce_if
//   Bundle carrying the raw switch levels into the debouncer and the
//   conditioned level, edge pulses and toggle latch back out.
//
//   Signals (all WIDTH bits, one bit per channel):
//     sw_in      raw asynchronous switch/button levels
//     sw_out     debounced level
//     sw_rise    one-cycle pulse when sw_out goes 0->1
//     sw_fall    one-cycle pulse when sw_out goes 1->0
//     sw_toggle  flips on every sw_rise
//
//   Modports:
//     master  board/consumer side: drives sw_in, observes the results
//     slave   debouncer side: samples sw_in, drives the results
// -----------------------------------------------------------------------------
interface sw_debounce_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] sw_in;
  logic [WIDTH-1:0] sw_out;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  logic [WIDTH-1:0] sw_toggle;

  modport master (
    output sw_in,
    input  sw_out,
    input  sw_rise,
    input  sw_fall,
    input  sw_toggle
  );

  modport slave (
    input  sw_in,
    output sw_out,
    output sw_rise,
    output sw_fall,
    output sw_toggle
  );
endinterface

// File: rtl/sw_debounce.sv
// -----------------------------------------------------------------------------
// sw_debounce
//   Conditions raw board switches/buttons before they reach the clock divider
//   and CPU. Each channel has a 2-flop synchroniser, a stable-time counter
//   filter, a clean level output, one-cycle rise/fall pulses and a toggle
//   latch that flips on every accepted rising edge. Channels share no state.
//
//   Parameters:
//     WIDTH   number of independent channels
//     STABLE  cycles a synchronised level must persist to be accepted (>=2)
//     CW      counter width, 2**CW must exceed STABLE
//
//   Ports:
//     clk    board clock, all logic on the rising edge
//     rst    synchronous active-low reset (0 = reset)
//     sw_if  slave side of sw_debounce_if (sw_in in; sw_out, sw_rise,
//            sw_fall, sw_toggle out)
//
//   Latency: with sw_in held from edge k, sw_out changes on edge k+STABLE+1.
// -----------------------------------------------------------------------------
module sw_debounce #(
  parameter int WIDTH  = 4,
  parameter int STABLE = 1000000,
  parameter int CW     = 20
) (
  input  logic          clk,
  input  logic          rst,
  sw_debounce_if.slave  sw_if
);

  // Count value on which a pending level is accepted.
  localparam logic [CW-1:0] LAST = CW'(STABLE - 1);

  // Filter state per channel is the accepted level itself.
  typedef enum logic {
    ST_LOW  = 1'b0,
    ST_HIGH = 1'b1
  } state_e;

  // Synchroniser registers.
  logic [WIDTH-1:0] sync1_p0_q;
  logic [WIDTH-1:0] sync2_p1_q;

  // Filter state and counters.
  state_e           state_q [WIDTH];
  state_e           state_d [WIDTH];
  logic [CW-1:0]    cnt_q   [WIDTH];
  logic [CW-1:0]    cnt_d   [WIDTH];

  // Output registers.
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] rise_d;
  logic [WIDTH-1:0] fall_q;
  logic [WIDTH-1:0] fall_d;
  logic [WIDTH-1:0] tog_q;
  logic [WIDTH-1:0] tog_d;

  // Per-channel decode.
  logic [WIDTH-1:0] pend;
  logic [WIDTH-1:0] acc;

  // Stable-time counter step: clear when nothing is pending (this also
  // gives the full restart on a bounce back), clear on acceptance, otherwise
  // count. The acceptance clear means the counter never reaches STABLE.
  function automatic logic [CW-1:0] cnt_step(input logic          pending,
                                             input logic [CW-1:0] cnt);
    if (!pending || (cnt == LAST)) begin
      return '0;
    end
    return cnt + CW'(1);
  endfunction

  for (genvar g = 0; g < WIDTH; g++) begin : g_decode
    assign pend[g] = sync2_p1_q[g] ^ logic'(state_q[g]);
    assign acc[g]  = pend[g] && (cnt_q[g] == LAST);
    assign sw_if.sw_out[g] = logic'(state_q[g]);
  end

  assign sw_if.sw_rise   = rise_q;
  assign sw_if.sw_fall   = fall_q;
  assign sw_if.sw_toggle = tog_q;

  // ---- next-state: filter FSM, pulses and toggle ----
  always_comb begin
    rise_d = '0;
    fall_d = '0;
    tog_d  = tog_q;
    for (int i = 0; i < WIDTH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_step(pend[i], cnt_q[i]);
      if (acc[i]) begin
        state_d[i] = state_e'(sync2_p1_q[i]);
        rise_d[i]  = sync2_p1_q[i];
        fall_d[i]  = ~sync2_p1_q[i];
        tog_d[i]   = tog_q[i] ^ sync2_p1_q[i];
      end
    end
  end

  // ---- stage p0/p1: synchroniser; filter and output registers ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_p0_q <= '0;
      sync2_p1_q <= '0;
      rise_q     <= '0;
      fall_q     <= '0;
      tog_q      <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= ST_LOW;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_p0_q <= sw_if.sw_in;
      sync2_p1_q <= sync1_p0_q;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      tog_q      <= tog_d;
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_sw_debounce.sv
module tb_sw_debounce;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  sw_debounce_if #(.WIDTH(4)) bus ();

  sw_debounce #(
    .WIDTH (4),
    .STABLE(4),
    .CW    (3)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .sw_if(bus)
  );

  initial clk = 1'b0;
  always #1 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s mismatched", tag);
    end
  endtask

  function automatic logic [15:0] all_outs();
    return {bus.sw_out, bus.sw_rise, bus.sw_fall, bus.sw_toggle};
  endfunction

  initial begin
    checks   = 0;
    failures = 0;
    rst       = 1'b0;
    bus.sw_in = 4'hF;

    // 1: reset held for three edges with all inputs high
    for (int j = 1; j <= 3; j++) begin
      tick();
      check("reset_outs", all_outs(), 16'h0000);
    end
    rst       = 1'b1;
    bus.sw_in = 4'h0;
    for (int j = 1; j <= 3; j++) begin
      tick();
      check("idle_outs", all_outs(), 16'h0000);
    end

    // 2: clean press on channel 0, accepted on edge k+5
    bus.sw_in = 4'b0001;
    for (int j = 1; j <= 5; j++) begin
      tick();
      check("press_wait_out", {12'h0, bus.sw_out}, 16'h0000);
    end
    tick();
    check("press_out",  {12'h0, bus.sw_out},    16'h0001);
    check("press_rise", {12'h0, bus.sw_rise},   16'h0001);
    check("press_tog",  {12'h0, bus.sw_toggle}, 16'h0001);
    tick();
    check("press_rise_end", {12'h0, bus.sw_rise}, 16'h0000);
    check("press_hold_out", {12'h0, bus.sw_out},  16'h0001);

    // 3: bounce on channel 1: 1,0,1,1,0,1 then steady
    bus.sw_in[1] = 1'b1; tick(); check("bounce_out", {12'h0, bus.sw_out}, 16'h0001);
    bus.sw_in[1] = 1'b0; tick(); check("bounce_out", {12'h0, bus.sw_out}, 16'h0001);
    bus.sw_in[1] = 1'b1; tick(); check("bounce_out", {12'h0, bus.sw_out}, 16'h0001);
    bus.sw_in[1] = 1'b1; tick(); check("bounce_out", {12'h0, bus.sw_out}, 16'h0001);
    bus.sw_in[1] = 1'b0; tick(); check("bounce_out", {12'h0, bus.sw_out}, 16'h0001);
    bus.sw_in[1] = 1'b1; tick(); check("bounce_out", {12'h0, bus.sw_out}, 16'h0001);
    for (int j = 2; j <= 7; j++) begin
      tick();
      check("bounce_settle_out",  {12'h0, bus.sw_out},  (j >= 6) ? 16'h0003 : 16'h0001);
      check("bounce_settle_rise", {12'h0, bus.sw_rise}, (j == 6) ? 16'h0002 : 16'h0000);
    end
    check("bounce_tog", {12'h0, bus.sw_toggle}, 16'h0003);

    // 4: channel 2 press / release / press with 10-cycle holds
    bus.sw_in[2] = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      tick();
      check("ch2_press1_rise", {12'h0, bus.sw_rise},   (j == 6) ? 16'h0004 : 16'h0000);
      check("ch2_press1_fall", {12'h0, bus.sw_fall},   16'h0000);
      check("ch2_press1_tog",  {12'h0, bus.sw_toggle}, (j >= 6) ? 16'h0007 : 16'h0003);
    end
    bus.sw_in[2] = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      tick();
      check("ch2_release_fall", {12'h0, bus.sw_fall},   (j == 6) ? 16'h0004 : 16'h0000);
      check("ch2_release_rise", {12'h0, bus.sw_rise},   16'h0000);
      check("ch2_release_out",  {12'h0, bus.sw_out},    (j >= 6) ? 16'h0003 : 16'h0007);
      check("ch2_release_tog",  {12'h0, bus.sw_toggle}, 16'h0007);
    end
    bus.sw_in[2] = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      tick();
      check("ch2_press2_rise", {12'h0, bus.sw_rise},   (j == 6) ? 16'h0004 : 16'h0000);
      check("ch2_press2_tog",  {12'h0, bus.sw_toggle}, (j >= 6) ? 16'h0003 : 16'h0007);
    end

    // 5: reset while channel 3 is at count 2
    bus.sw_in = 4'hF;
    for (int j = 1; j <= 4; j++) tick();
    check("midcount_out", {12'h0, bus.sw_out}, 16'h0007);
    rst = 1'b0;
    tick();
    check("midcount_reset_outs", all_outs(), 16'h0000);
    rst = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      tick();
      check("post_reset_out",  {12'h0, bus.sw_out},  (j == 6) ? 16'h000F : 16'h0000);
      check("post_reset_rise", {12'h0, bus.sw_rise}, (j == 6) ? 16'h000F : 16'h0000);
      check("post_reset_fall", {12'h0, bus.sw_fall}, 16'h0000);
    end
    check("post_reset_tog", {12'h0, bus.sw_toggle}, 16'h000F);

    // 6: all released, then channels 3 and 1 pressed together
    bus.sw_in = 4'h0;
    for (int j = 1; j <= 10; j++) begin
      tick();
      check("all_release_fall", {12'h0, bus.sw_fall}, (j == 6) ? 16'h000F : 16'h0000);
    end
    bus.sw_in = 4'b1010;
    for (int j = 1; j <= 7; j++) begin
      tick();
      check("simul_out",  {12'h0, bus.sw_out},  (j >= 6) ? 16'h000A : 16'h0000);
      check("simul_rise", {12'h0, bus.sw_rise}, (j == 6) ? 16'h000A : 16'h0000);
    end
    check("simul_tog", {12'h0, bus.sw_toggle}, 16'h0005);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
